// File: rtl/uart_receiver.sv
// UART receiver: 8N1 frames, OVERSAMPLE sysclk cycles per bit, one-cycle data/error pulses.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around every sample point.
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 8
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_STATUS,
    output logic       RX_ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_sync1;
    logic               r_sync2;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_status;
    logic               r_err;
    logic               w_rxs;
    logic               w_tick;
    logic               w_sample;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= UART_RX;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs  = r_sync2;
    assign w_tick = (r_cnt == CNT_MID);

`ifdef UART_RX_MAJORITY_EN
    logic r_rxs_d;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) r_rxs_d <= 1'b1;
        else        r_rxs_d <= w_rxs;
    end

    // r_sync1 is the value rxs takes on the next cycle, giving the +1 sample
    // without shifting the decision edge relative to the single-sample build.
    assign w_sample = (r_rxs_d & w_rxs) | (r_rxs_d & r_sync1) | (w_rxs & r_sync1);
`else
    assign w_sample = w_rxs;
`endif

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_rxs) w_next = S_START;
            S_START: if (w_tick) w_next = w_sample ? S_IDLE : S_DATA;
            S_DATA:  if (w_tick && r_idx == 3'd7) w_next = S_STOP;
            S_STOP:  if (w_tick) w_next = w_sample ? S_IDLE : S_BREAK;
            S_BREAK: if (w_rxs) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_idx    <= 3'd0;
            r_shift  <= 8'h00;
            r_data   <= 8'h00;
            r_status <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_status <= 1'b0;
            r_err    <= 1'b0;
            // Counter is held at 0 in IDLE, so the falling-edge cycle is T0.
            if (r_state == S_IDLE || r_cnt == CNT_LAST) r_cnt <= '0;
            else                                        r_cnt <= r_cnt + CNT_W'(1);

            if (w_tick) begin
                case (r_state)
                    S_START: r_idx <= 3'd0;
                    S_DATA: begin
                        r_shift[r_idx] <= w_sample;
                        r_idx          <= r_idx + 3'd1;
                    end
                    S_STOP: begin
                        if (w_sample) begin
                            r_data   <= r_shift;
                            r_status <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign RX_DATA   = r_data;
    assign RX_STATUS = r_status;
    assign RX_ERR    = r_err;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames push expected pulses, a monitor checks them.
module tb_uart_receiver;

    localparam int OS      = 16;
    localparam int LATENCY = 2 + OS / 2 + 9 * OS + 1;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b0;
    logic       UART_RX = 1'b1;
    logic [7:0] RX_DATA;
    logic       RX_STATUS;
    logic       RX_ERR;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_pulse = 1'b0;

    uart_receiver #(.OVERSAMPLE(OS), .CNT_W(8)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .UART_RX  (UART_RX),
        .RX_DATA  (RX_DATA),
        .RX_STATUS(RX_STATUS),
        .RX_ERR   (RX_ERR)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output pulse pops one expected event.
    always @(negedge sysclk) begin
        if (reset && (RX_STATUS || RX_ERR)) begin
            checks++;
            if (prev_pulse || (RX_STATUS && RX_ERR)) begin
                errors++;
                $display("FAIL pulse_shape: status=%0b err=%0b prev=%0b at cycle %0d",
                         RX_STATUS, RX_ERR, prev_pulse, cyc);
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious: status=%0b err=%0b at cycle %0d, expected none",
                         RX_STATUS, RX_ERR, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind_err", int'(RX_ERR), int'(e.err));
                check("rx_data", int'(RX_DATA), int'(e.data));
                checks++;
                if (cyc < e.at - 1 || cyc > e.at + 1) begin
                    errors++;
                    $display("FAIL latency: pulse at cycle %0d expected %0d", cyc, e.at);
                end
            end
        end
        prev_pulse = RX_STATUS || RX_ERR;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    // Drives ncyc cycles of a frame; glitch forces the line high for that one cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int glitch,
                              input int ncyc, input logic push,
                              input logic exp_err, input logic [7:0] exp_data);
        logic v;
        if (push) sb.push_back('{err: exp_err, data: exp_data, at: cyc + LATENCY});
        for (int c = 0; c < ncyc; c++) begin
            if (c < OS)            v = 1'b0;
            else if (c < 9 * OS)   v = d[(c - OS) / OS];
            else                   v = stop_bit;
            if (c == glitch) v = 1'b1;
            UART_RX = v;
            @(posedge sysclk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] glitch_exp;
`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'h00;
`else
        glitch_exp = 8'h08;
`endif
        idle(3);
        check("reset_data", int'(RX_DATA), 0);
        check("reset_status", int'(RX_STATUS), 0);
        check("reset_err", int'(RX_ERR), 0);
        reset = 1'b1;
        idle(10);

        send_frame(8'h55, 1'b1, -1, 10 * OS, 1'b1, 1'b0, 8'h55);
        idle(20);

        send_frame(8'hA3, 1'b1, -1, 10 * OS, 1'b1, 1'b0, 8'hA3);
        send_frame(8'h0F, 1'b1, -1, 10 * OS, 1'b1, 1'b0, 8'h0F);
        idle(20);

        UART_RX = 1'b0;
        idle(4);
        UART_RX = 1'b1;
        idle(30);
        send_frame(8'h3C, 1'b1, -1, 10 * OS, 1'b1, 1'b0, 8'h3C);
        idle(20);

        send_frame(8'h81, 1'b0, -1, 10 * OS, 1'b1, 1'b1, 8'h3C);
        idle(40);
        UART_RX = 1'b1;
        idle(30);
        send_frame(8'h7E, 1'b1, -1, 10 * OS, 1'b1, 1'b0, 8'h7E);
        idle(20);

        // Abort mid data bit 4.
        send_frame(8'hFF, 1'b1, -1, 5 * OS + OS / 2, 1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        UART_RX = 1'b1;
        idle(3);
        check("abort_data", int'(RX_DATA), 0);
        check("abort_status", int'(RX_STATUS), 0);
        reset = 1'b1;
        idle(200);
        check("post_abort_data", int'(RX_DATA), 0);
        send_frame(8'h12, 1'b1, -1, 10 * OS, 1'b1, 1'b0, 8'h12);
        idle(20);

        // Glitch one cycle at mid bit 3 (lands on the bit-3 sample point).
        send_frame(8'h00, 1'b1, 4 * OS + OS / 2, 10 * OS, 1'b1, 1'b0, glitch_exp);
        idle(200);

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
